// File: rtl/reg_xfer_ctrl_if.sv
// Control, stream and register-file signals of reg_xfer_ctrl; master = controller side.
// cksum_err is present only when REG_XFER_CKSUM_EN is defined.
interface reg_xfer_ctrl_if #(
    parameter int AddressSize = 3,
    parameter int WordSize    = 8
);
    logic                   start;
    logic                   mode;
    logic                   busy;
    logic                   done;
    logic [WordSize-1:0]    s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic [WordSize-1:0]    m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [AddressSize-1:0] rf_ra;
    logic [WordSize-1:0]    rf_rdata;
    logic [AddressSize-1:0] rf_rw;
    logic [WordSize-1:0]    rf_wdata;
    logic                   rf_RegWr;
`ifdef REG_XFER_CKSUM_EN
    logic                   cksum_err;
`endif

    modport master (
        input  start, mode, s_data, s_valid, m_ready, rf_rdata,
        output busy, done, s_ready, m_data, m_valid, rf_ra, rf_rw, rf_wdata, rf_RegWr
`ifdef REG_XFER_CKSUM_EN
        , output cksum_err
`endif
    );

    modport slave (
        output start, mode, s_data, s_valid, m_ready, rf_rdata,
        input  busy, done, s_ready, m_data, m_valid, rf_ra, rf_rw, rf_wdata, rf_RegWr
`ifdef REG_XFER_CKSUM_EN
        , input cksum_err
`endif
    );
endinterface

// File: rtl/reg_xfer_ctrl.sv
// Streams a register file in (load) or out (dump); REG_XFER_CKSUM_EN adds a trailing XOR beat.
// Latency: one beat per handshake cycle, done pulses the cycle after the last beat.
// Backpressure: s_valid/m_ready stalls hold addr and data; nothing is lost or repeated.
module reg_xfer_ctrl #(
    parameter int AddressSize = 3,
    parameter int WordSize    = 8
) (
    input logic             clk,
    input logic             rst_n,
    reg_xfer_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, DUMP, CKSUM, DONE} state_t;
    localparam logic [AddressSize-1:0] LastAddr = '1;

    state_t                 state;
    logic [AddressSize-1:0] addr;
    logic                   busy_q;
    logic                   done_q;
    logic                   data_hs;

    assign data_hs      = (state == LOAD && bus.s_valid) || (state == DUMP && bus.m_ready);
    assign bus.rf_ra    = addr;
    assign bus.rf_rw    = addr;
    assign bus.rf_wdata = bus.s_data;
    assign bus.rf_RegWr = (state == LOAD) && bus.s_valid;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef REG_XFER_CKSUM_EN
    logic                dir;
    logic [WordSize-1:0] cksum;
    logic                cksum_err_q;
    logic [WordSize-1:0] beat;

    assign beat          = (state == LOAD) ? bus.s_data : bus.rf_rdata;
    assign bus.s_ready   = (state == LOAD) || (state == CKSUM && !dir);
    assign bus.m_valid   = (state == DUMP) || (state == CKSUM && dir);
    assign bus.m_data    = (state == CKSUM) ? cksum : bus.rf_rdata;
    assign bus.cksum_err = cksum_err_q;
`else
    assign bus.s_ready = (state == LOAD);
    assign bus.m_valid = (state == DUMP);
    assign bus.m_data  = WordSize'(bus.rf_rdata);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef REG_XFER_CKSUM_EN
            dir         <= 1'b0;
            cksum       <= '0;
            cksum_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr   <= '0;
                        busy_q <= 1'b1;
                        state  <= bus.mode ? DUMP : LOAD;
`ifdef REG_XFER_CKSUM_EN
                        dir         <= bus.mode;
                        cksum       <= '0;
                        cksum_err_q <= 1'b0;
`endif
                    end
                end
                LOAD, DUMP: begin
                    if (data_hs) begin
                        addr <= addr + 1'b1;
`ifdef REG_XFER_CKSUM_EN
                        cksum <= cksum ^ beat;
`endif
                        // The last entry ends the data phase; addr wrapping to 0 is never used.
                        if (addr == LastAddr) begin
`ifdef REG_XFER_CKSUM_EN
                            state <= CKSUM;
`else
                            state  <= DONE;
                            done_q <= 1'b1;
`endif
                        end
                    end
                end
                CKSUM: begin
`ifdef REG_XFER_CKSUM_EN
                    if (dir ? bus.m_ready : bus.s_valid) begin
                        if (!dir) cksum_err_q <= (bus.s_data != cksum);
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/reg_xfer_ctrl.md
REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

Interface
REQ-001 SHALL have parameter AddressSize, default 3, register address width.
REQ-002 SHALL have parameter WordSize, default 8, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a transfer, sampled in IDLE only.
REQ-006 SHALL have port mode  input  1  sampled with start: 0 = load (stream to register file), 1 = dump (register file to stream).
REQ-007 SHALL have port busy  output  1  high while not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports s_data/s_valid/s_ready  input/input/output  WordSize/1/1  load input stream.
REQ-010 SHALL have ports m_data/m_valid/m_ready  output/output/input  WordSize/1/1  dump output stream.
REQ-011 SHALL have ports rf_ra  output  AddressSize, rf_rdata  input  WordSize  register file asynchronous read port.
REQ-012 SHALL have ports rf_rw  output  AddressSize, rf_wdata  output  WordSize, rf_RegWr  output  1  register file write port.

Function
REQ-013 SHALL implement states IDLE, LOAD, DUMP, CKSUM, DONE, plus an address counter addr of AddressSize bits.
REQ-014 SHALL, in IDLE with start=1, clear addr and go to LOAD (mode=0) or DUMP (mode=1); start outside IDLE is ignored.
REQ-015 SHALL, in LOAD, drive s_ready=1, rf_rw=addr, rf_wdata=s_data, rf_RegWr=s_valid combinationally, so each accepted beat is written on the same clock edge.
REQ-016 SHALL, in DUMP, drive rf_ra=addr, m_data=rf_rdata, m_valid=1; m_data stays stable until the m_valid&m_ready handshake.
REQ-017 SHALL increment addr on every handshake; a handshake at addr = 2^AddressSize-1 ends the data phase, with no wrap to entry 0 within a transfer.
REQ-018 SHALL go from DONE back to IDLE after exactly one cycle, with done=1 only in DONE.
REQ-019 SHALL hold s_ready=0, m_valid=0 and rf_RegWr=0 in every state other than LOAD or DUMP, except as given in REQ-024.
REQ-020 SHALL tolerate arbitrary valid/ready stalls, with no beat lost or duplicated; a full 8-entry transfer with no stalls takes 8 data cycles plus 1 DONE cycle.
REQ-021 SHALL drive rf_ra=addr in all states.

Reset
REQ-022 SHALL, when rst_n is low, immediately force state=IDLE, addr=0, busy=0, done=0, s_ready=0, m_valid=0, rf_RegWr=0, and the cksum register to 0.
REQ-023 SHALL, on reset mid-transfer, abort with no further write; entries already written keep their values.

Configuration
REQ-024 SHALL, when macro REG_XFER_CKSUM_EN is defined, keep a running XOR of all data beats and use state CKSUM after the last data beat:
- Dump: sends one extra beat carrying the XOR.
- Load: accepts one extra beat; output cksum_err (1 bit, registered) is set when that beat differs from the XOR and cleared on the next start.
REQ-025 SHALL, without REG_XFER_CKSUM_EN, go directly from the last data beat to DONE, with no CKSUM state, no cksum logic and no cksum_err port.

Verification
REQ-026 SHALL cover load: start, mode=0, then beats 0x11..0x88 with no stalls. Required response: rf_RegWr high 8 cycles, rf_rw 0..7, done pulses one cycle after the last beat.
REQ-027 SHALL cover dump: register file holds 0xA0+i, m_ready toggles every cycle. Required response: m_data sequence 0xA0..0xA7 exactly once each, with m_data stable while stalled.
REQ-028 SHALL cover start held high during a transfer and start pulsed in DONE. Required response: both ignored, busy stays high until DONE, no second transfer starts.
REQ-029 SHALL cover rst_n low after 3 load beats. Required response: busy=0 and rf_RegWr=0 immediately, entries 0..2 updated, entries 3..7 unchanged.
REQ-030 SHALL cover, with REG_XFER_CKSUM_EN defined:
- Dump of 0x01..0x08 -> ninth beat 0x08.
- Load of 0x01..0x08 then 0x00 -> cksum_err=1.
- Load of 0x01..0x08 then 0x08 -> cksum_err=0.
